// File: rtl/i2c_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the I2C target.
// Contents: I2C_ADDR_W, I2C_DATA_W, I2C_CNT_W, i2c_state_e, maj3().
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam int unsigned I2C_CNT_W  = 4;

  // Bit counter value after the last data/address bit of a byte
  localparam logic [I2C_CNT_W-1:0] I2C_LAST_BIT = I2C_CNT_W'(I2C_DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    IGNORE
  } i2c_state_e;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Purpose: synchronise one bus line into clk, optionally glitch-filter it,
//          and flag its rising/falling edges.
// Config : I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter
//          (2 extra clk of latency).
// Ports  : clk, reset (async, active-high), line_i (raw bus line),
//          level_o (filtered level), rise_o / fall_o (one-clk edge flags).
// All outputs are registered and mutually aligned.
module i2c_sync_edge
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
  logic rise_q,  rise_d;
  logic fall_q,  fall_d;
  logic filt;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] hist_q, hist_d;
`endif

  // Synchroniser, optional filter and edge detect
  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    hist_d  = {hist_q[1:0], sync2_q};
    filt    = maj3(hist_q);
`else
    filt    = sync2_q;
`endif
    level_d = filt;
    rise_d  = filt & ~level_q;
    fall_d  = ~filt & level_q;
  end

  // Reset to 0 so that lines returning high after reset can only look like
  // a rising edge (harmless STOP), never a false START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      hist_q  <= 3'b000;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// Purpose: I2C target with one 7-bit address; byte-stream write and read.
// Config : I2C_SLAVE_GLITCH_FILTER_EN enables majority filtering of SCL/SDA.
// Ports  : clk, reset (async, active-high), i2c_scl (in), i2c_sda (open-drain),
//          rx_data/rx_valid (written byte + one-clk strobe),
//          tx_data/tx_req (read byte, captured during the tx_req pulse),
//          busy (START .. STOP or NACKed address).
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h55
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_DATA_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c;

  i2c_state_e              state_q,    state_d;
  logic [I2C_CNT_W-1:0]    cnt_q,      cnt_d;
  logic [I2C_DATA_W-1:0]   shift_q,    shift_d;
  logic                    rw_q,       rw_d;
  logic                    sda_oe_q,   sda_oe_d;
  logic [I2C_DATA_W-1:0]   rx_data_q,  rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_req_q,   tx_req_d;
  logic                    busy_q,     busy_d;

  i2c_sync_edge u_scl (
    .clk     (clk),
    .reset   (reset),
    .line_i  (i2c_scl),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk     (clk),
    .reset   (reset),
    .line_i  (i2c_sda),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;

    if (stop_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_DATA_W-2:0], sda_lvl};
            cnt_d   = cnt_q + I2C_CNT_W'(1);
          end else if (scl_fall && cnt_q == I2C_LAST_BIT) begin
            if (shift_q[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              busy_d   = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            if (rw_q) begin
              tx_req_d = 1'b1;
              state_d  = READ;
            end else begin
              state_d  = WRITE;
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_DATA_W-2:0], sda_lvl};
            cnt_d   = cnt_q + I2C_CNT_W'(1);
            if (cnt_q == I2C_LAST_BIT - I2C_CNT_W'(1)) begin
              rx_data_d  = {shift_q[I2C_DATA_W-2:0], sda_lvl};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == I2C_LAST_BIT) begin
            sda_oe_d = 1'b1;
            state_d  = WRITE_ACK;
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            state_d  = WRITE;
          end
        end
        READ: begin
          // The cycle tx_req is high: capture tx_data and present its MSB;
          // SCL is low here since the triggering fall was one clk earlier.
          if (tx_req_q) begin
            sda_oe_d = ~tx_data[I2C_DATA_W-1];
            shift_d  = {tx_data[I2C_DATA_W-2:0], 1'b0};
          end else if (scl_rise) begin
            cnt_d = cnt_q + I2C_CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt_q == I2C_LAST_BIT) begin
              sda_oe_d = 1'b0;
              state_d  = READ_ACK;
            end else begin
              sda_oe_d = ~shift_q[I2C_DATA_W-1];
              shift_d  = {shift_q[I2C_DATA_W-2:0], 1'b0};
            end
          end
        end
        READ_ACK: begin
          if (scl_rise && sda_lvl) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            cnt_d    = '0;
            tx_req_d = 1'b1;
            state_d  = READ;
          end
        end
        IDLE, IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset releases SDA immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Purpose: directed bench for i2c_slave; a bit-banged master drives the bus,
//          expected rx/tx events are queued and matched by a monitor.
module tb_i2c_slave;

  localparam int T = 200;  // quarter SCL period in ns

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda_low;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h55)) dut (
    .clk      (clk),
    .reset    (reset),
    .i2c_scl  (scl),
    .i2c_sda  (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_tx;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  checks = 0;
  int  errors = 0;
  int  dut_low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts DUT-driven lows and matches rx/tx strobes to the queue
  always @(negedge clk) begin
    if (!sda_bus && !m_sda_low) dut_low_cnt++;
    if (rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_valid: unexpected pulse with rx_data 0x%0h, expected none", rx_data);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.is_tx || rx_data !== mon_ev.data) begin
          errors++;
          $display("FAIL rx_event: got rx 0x%0h, expected is_tx=%0b data 0x%0h",
                   rx_data, mon_ev.is_tx, mon_ev.data);
        end
      end
    end
    if (tx_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_req: unexpected pulse, expected none");
      end else begin
        mon_ev = exp_q.pop_front();
        if (!mon_ev.is_tx) begin
          errors++;
          $display("FAIL tx_event: got tx_req, expected rx of 0x%0h", mon_ev.data);
        end
      end
    end
  end

  task automatic bus_start();
    m_sda_low = 1'b1; #T;
    scl = 1'b0;       #T;
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0; #T;
    scl = 1'b1;       #T;
    m_sda_low = 1'b1; #T;
    scl = 1'b0;       #T;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #T;
    scl = 1'b1;       #T;
    m_sda_low = 1'b0; #(2*T);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #T;
    scl = 1'b1;     #(2*T);
    scl = 1'b0;     #T;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #T;
    scl = 1'b1;       #T;
    b = sda_bus;      #T;
    scl = 1'b0;       #T;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  logic       ack;
  logic       b;
  logic [7:0] d;
  int         low0;

  initial begin
    scl = 1'b1; m_sda_low = 1'b0; tx_data = 8'h00; reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_tx_req", 32'(tx_req), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sda", 32'(sda_bus), 32'h1);
    reset = 1'b0;
    #(4*T);

    // Write 0x55/W, data 0xAA
    exp_q.push_back('{is_tx: 1'b0, data: 8'hAA});
    bus_start();
    check("w_busy_after_start", 32'(busy), 32'h1);
    write_byte(8'hAA, ack); check("w_addr_ack", 32'(ack), 32'h0);
    write_byte(8'hAA, ack); check("w_data_ack", 32'(ack), 32'h0);
    bus_stop();
    check("w_busy_after_stop", 32'(busy), 32'h0);
    check("w_rx_data", 32'(rx_data), 32'hAA);

    // Address 0x54: never acknowledged, data ignored
    low0 = dut_low_cnt;
    bus_start();
    write_byte(8'hA8, ack); check("nm_addr_nack", 32'(ack), 32'h1);
    check("nm_busy_dropped", 32'(busy), 32'h0);
    write_byte(8'h5A, ack); check("nm_data_nack", 32'(ack), 32'h1);
    check("nm_busy_ignore", 32'(busy), 32'h0);
    bus_stop();
    check("nm_no_sda_drive", 32'(dut_low_cnt - low0), 32'h0);

    // Read 0x55 with tx_data 0x3C, master NACK
    tx_data = 8'h3C;
    exp_q.push_back('{is_tx: 1'b1, data: 8'h00});
    bus_start();
    write_byte(8'hAB, ack); check("r_addr_ack", 32'(ack), 32'h0);
    read_byte(d, 1'b1);     check("r_data", 32'(d), 32'h3C);
    low0 = dut_low_cnt;
    read_bit(b);            check("r_ignore_released", 32'(b), 32'h1);
    check("r_busy_in_ignore", 32'(busy), 32'h1);
    bus_stop();
    check("r_no_drive_after_nack", 32'(dut_low_cnt - low0), 32'h0);
    check("r_busy_after_stop", 32'(busy), 32'h0);

    // Write 0x11, repeated START, read two bytes (ACK then NACK)
    exp_q.push_back('{is_tx: 1'b0, data: 8'h11});
    exp_q.push_back('{is_tx: 1'b1, data: 8'h00});
    exp_q.push_back('{is_tx: 1'b1, data: 8'h00});
    tx_data = 8'hC5;
    bus_start();
    write_byte(8'hAA, ack); check("rs_waddr_ack", 32'(ack), 32'h0);
    write_byte(8'h11, ack); check("rs_wdata_ack", 32'(ack), 32'h0);
    bus_rstart();
    check("rs_busy", 32'(busy), 32'h1);
    write_byte(8'hAB, ack); check("rs_raddr_ack", 32'(ack), 32'h0);
    check("rs_rx_data", 32'(rx_data), 32'h11);
    read_byte(d, 1'b0);     check("rs_rdata0", 32'(d), 32'hC5);
    read_byte(d, 1'b1);     check("rs_rdata1", 32'(d), 32'hC5);
    bus_stop();

    // Reset at bit 4 of a written data byte
    bus_start();
    write_byte(8'hAA, ack); check("rst_addr_ack", 32'(ack), 32'h0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    reset = 1'b1;
    #1;
    check("rst_sda", 32'(sda_bus), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
    read_bit(ack); check("rst_rest_nack", 32'(ack), 32'h1);
    bus_stop();
    exp_q.push_back('{is_tx: 1'b0, data: 8'h3E});
    bus_start();
    write_byte(8'hAA, ack); check("post_rst_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h3E, ack); check("post_rst_data_ack", 32'(ack), 32'h0);
    bus_stop();

    // Reset while the target drives a 0 data bit on a read
    tx_data = 8'h00;
    exp_q.push_back('{is_tx: 1'b1, data: 8'h00});
    bus_start();
    write_byte(8'hAB, ack); check("rrst_addr_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 3; i++) begin
      read_bit(b); check("rrst_bit", 32'(b), 32'h0);
    end
    check("rrst_driving", 32'(sda_bus), 32'h0);
    reset = 1'b1;
    #1;
    check("rrst_released", 32'(sda_bus), 32'h1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus_stop();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clk SDA low pulse while SCL is high must not look like START/STOP
    exp_q.push_back('{is_tx: 1'b0, data: 8'hFF});
    bus_start();
    write_byte(8'hAA, ack); check("gl_addr_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 8; i++) begin
      m_sda_low = 1'b0; #T;
      scl = 1'b1;       #T;
      if (i == 3) begin
        @(posedge clk); #2 m_sda_low = 1'b1;
        @(posedge clk); #2 m_sda_low = 1'b0;
      end
      #T;
      scl = 1'b0; #T;
    end
    read_bit(ack); check("gl_data_ack", 32'(ack), 32'h0);
    check("gl_busy", 32'(busy), 32'h1);
    bus_stop();
`endif

    #(4*T);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
